// File: rtl/tag_nios_mem_pkg.sv
// tag_nios_mem_pkg: shared collision-FSM state type and default memory parameters
package tag_nios_mem_pkg;
  typedef enum logic {IDLE, STALL2} coll_state_t;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 13;
  localparam int DEF_DEPTH   = 8192;
  localparam int DEF_OUT_REG = 0;
endpackage

// File: rtl/tag_nios_mem_rdpipe.sv
// tag_nios_mem_rdpipe: read valid/data delay line of depth 1+OUT_REG behind the RAM output register
module tag_nios_mem_rdpipe #(
  parameter int DATA_W  = 32,
  parameter int OUT_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              acc,
  input  logic [DATA_W-1:0] ram_q,
  output logic              valid,
  output logic [DATA_W-1:0] data
);
  logic v1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) v1 <= 1'b0;
    else if (en) v1 <= acc;
  if (OUT_REG != 0) begin : g_reg
    logic              v2;
    logic [DATA_W-1:0] d2;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else if (en) begin
        v2 <= v1;
        if (v1) d2 <= ram_q;
      end
    assign valid = v2 & en;
    assign data  = d2;
  end else begin : g_raw
    assign valid = v1 & en;
    assign data  = ram_q;
  end
endmodule

// File: rtl/tag_nios_dp_onchip_memory.sv
// tag_nios_dp_onchip_memory: dual-port Avalon-MM on-chip RAM with byte enables and s1-priority write collisions
module tag_nios_dp_onchip_memory
  import tag_nios_mem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int OUT_REG = DEF_OUT_REG,
  parameter     INIT_FILE = "tag_nios_dp_onchip_memory.hex"
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clken,
  input  logic                reset_req,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic                s1_waitrequest,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic                s2_waitrequest,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid
);
  localparam int NB = DATA_W / 8;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DATA_W-1:0] mem [DEPTH];
  // power-up contents are supplied from INIT_FILE by the device configuration flow
  logic unused_init;
  assign unused_init = ^INIT_FILE;
  coll_state_t state;
  logic en, st2, rd1, wr1, rd2, wr2, in1, in2, coll, w2_en, w2_in;
  logic [ADDR_W-1:0] p_addr, w2_addr;
  logic [DATA_W-1:0] p_data, w2_data, q1, q2;
  logic [NB-1:0]     p_be, w2_be;
  assign en  = clken & ~reset_req;
  assign st2 = state == STALL2;
  assign s1_waitrequest = ~en;
  assign s2_waitrequest = ~en | st2;
  assign wr1  = en & s1_chipselect & s1_write;
  assign rd1  = en & s1_chipselect & s1_read & ~s1_write;
  assign wr2  = en & ~st2 & s2_chipselect & s2_write;
  assign rd2  = en & ~st2 & s2_chipselect & s2_read & ~s2_write;
  assign in1  = 32'(s1_address) < DEPTH;
  assign in2  = 32'(s2_address) < DEPTH;
  assign coll = wr1 & wr2 & (s1_address == s2_address);
  // port-2 write side: the deferred s2 write owns it while stalled
  assign w2_en   = st2 ? en : wr2 & ~coll;
  assign w2_addr = st2 ? p_addr : s2_address;
  assign w2_data = st2 ? p_data : s2_writedata;
  assign w2_be   = st2 ? p_be : s2_byteenable;
  assign w2_in   = 32'(w2_addr) < DEPTH;
  always_ff @(posedge clk) begin
    if (rd1) q1 <= in1 ? mem[s1_address[IW-1:0]] : '0;
    if (rd2) q2 <= in2 ? mem[s2_address[IW-1:0]] : '0;
    for (int b = 0; b < NB; b++) begin
      if (wr1 & in1 & s1_byteenable[b]) mem[s1_address[IW-1:0]][b*8 +: 8] <= s1_writedata[b*8 +: 8];
      if (w2_en & w2_in & w2_be[b]) mem[w2_addr[IW-1:0]][b*8 +: 8] <= w2_data[b*8 +: 8];
    end
  end
  always_ff @(posedge clk)
    if (coll) begin
      p_addr <= s2_address;
      p_data <= s2_writedata;
      p_be   <= s2_byteenable;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else if (en) state <= coll ? STALL2 : IDLE;
  tag_nios_mem_rdpipe #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_pipe1 (
    .clk(clk), .rst_n(reset_n), .en(en), .acc(rd1), .ram_q(q1),
    .valid(s1_readdatavalid), .data(s1_readdata)
  );
  tag_nios_mem_rdpipe #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_pipe2 (
    .clk(clk), .rst_n(reset_n), .en(en), .acc(rd2), .ram_q(q2),
    .valid(s2_readdatavalid), .data(s2_readdata)
  );
endmodule
